// File: rtl/counter_capture_pkg.sv
// Shared defaults and helpers for the counter capture FIFO.
package counter_capture_pkg;

    localparam int CC_WIDTH      = 16;
    localparam int CC_DEPTH      = 8;
    localparam int CC_MODE_RAW   = 0;
    localparam int CC_MODE_DELTA = 1;

    function automatic int cc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/counter_capture_fifo_if.sv
// Capture-side inputs and valid/ready output bus of the counter capture FIFO.
interface counter_capture_fifo_if
    import counter_capture_pkg::*;
#(
    parameter int WIDTH = CC_WIDTH,
    parameter int DEPTH = CC_DEPTH
);
    logic [WIDTH-1:0]            i_value;
    logic                        i_capture;
    logic                        i_clear;
    logic [WIDTH-1:0]            o_data;
    logic                        o_valid;
    logic                        i_ready;
    logic [cc_ptr_w(DEPTH):0]    o_count;
    logic                        o_full;
    logic                        o_overflow;

    modport master (
        output i_value, i_capture, i_clear, i_ready,
        input  o_data, o_valid, o_count, o_full, o_overflow
    );

    modport slave (
        input  i_value, i_capture, i_clear, i_ready,
        output o_data, o_valid, o_count, o_full, o_overflow
    );
endinterface

// File: rtl/counter_capture_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO with a registered head word,
// accepting a push while full when a pop happens in the same cycle.
module sync_fifo
    import counter_capture_pkg::*;
#(
    parameter int   WIDTH = CC_WIDTH,
    parameter int   DEPTH = CC_DEPTH,
    localparam int  PTR_W = cc_ptr_w(DEPTH),
    localparam int  CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] head_q, head_nxt;
    logic             full, empty, push_ok, pop_ok;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign pop_ok     = i_pop && !empty;
    assign push_ok    = i_push && (!full || pop_ok);
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    // Head register mirrors mem[rd_ptr] so o_data is a flop output, and it
    // keeps its old value once the FIFO runs empty.
    always_comb begin
        count_nxt = count_q;
        head_nxt  = head_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
        if (push_ok && (empty || (count_q == CNT_W'(1) && pop_ok))) begin
            head_nxt = i_wdata;
        end else if (pop_ok && count_q > CNT_W'(1)) begin
            head_nxt = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_inc;
            count_q <= count_nxt;
            head_q  <= head_nxt;
        end
    end

    assign o_rdata = head_q;
    assign o_count = count_q;
    assign o_full  = full;
    assign o_empty = empty;
endmodule

// File: rtl/counter_capture_fifo.sv
// Snapshots the shared counter on each capture strobe (raw or delta since the
// last accepted capture) and queues the snapshots on a valid/ready output.
module counter_capture_fifo
    import counter_capture_pkg::*;
#(
    parameter int WIDTH      = CC_WIDTH,
    parameter int DEPTH      = CC_DEPTH,
    parameter int DELTA_MODE = CC_MODE_RAW
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    counter_capture_fifo_if.slave bus
);
    localparam int CNT_W = cc_ptr_w(DEPTH) + 1;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] count;
    logic             full, empty, pop, push_acc, overflow_q;

    function automatic logic [WIDTH-1:0] delta_wrap(input logic [WIDTH-1:0] cur,
                                                    input logic [WIDTH-1:0] prv);
        return cur - prv;
    endfunction

    assign pop      = !empty && bus.i_ready && !bus.i_clear;
    assign push_acc = bus.i_capture && !bus.i_clear && (!full || pop);
    assign word     = (DELTA_MODE == CC_MODE_DELTA) ? delta_wrap(bus.i_value, prev_q)
                                                    : bus.i_value;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (bus.i_clear),
        .i_push  (push_acc),
        .i_pop   (pop),
        .i_wdata (word),
        .o_rdata (head),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    // A dropped capture leaves prev untouched so the next delta spans the gap.
    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_clear) begin
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) prev_q <= bus.i_value;
            if (bus.i_capture && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.o_data     = head;
    assign bus.o_valid    = !empty;
    assign bus.o_count    = count;
    assign bus.o_full     = full;
    assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_counter_capture_fifo.sv
// Directed bench: a raw-mode and a delta-mode instance driven by the same stimulus.
module tb_counter_capture_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        capture = 1'b0;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    counter_capture_fifo_if #(.WIDTH(16), .DEPTH(8)) ifr ();
    counter_capture_fifo_if #(.WIDTH(16), .DEPTH(8)) ifd ();

    assign ifr.i_value = value;   assign ifd.i_value = value;
    assign ifr.i_capture = capture; assign ifd.i_capture = capture;
    assign ifr.i_clear = clear;   assign ifd.i_clear = clear;
    assign ifr.i_ready = ready;   assign ifd.i_ready = ready;

    counter_capture_fifo #(.WIDTH(16), .DEPTH(8), .DELTA_MODE(0)) dut_raw (
        .i_clk(clk), .i_reset(rst), .bus(ifr.slave));
    counter_capture_fifo #(.WIDTH(16), .DEPTH(8), .DELTA_MODE(1)) dut_delta (
        .i_clk(clk), .i_reset(rst), .bus(ifd.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [15:0] v);
        value   = v;
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", ifr.o_count, 0);
        chk("rst_valid", ifr.o_valid, 0);
        chk("rst_full", ifr.o_full, 0);
        chk("rst_ovf", ifr.o_overflow, 0);
        chk("rst_data", ifr.o_data, 0);
        chk("rst_data_d", ifd.o_data, 0);

        // Basic raw capture then drain
        cap(16'h0010); cap(16'h0020); cap(16'h0030);
        chk("basic_count", ifr.o_count, 3);
        chk("basic_valid", ifr.o_valid, 1);
        chk("basic_d0", ifr.o_data, 16'h0010);
        ready = 1'b1;
        tick();
        chk("basic_d1", ifr.o_data, 16'h0020);
        chk("basic_cnt2", ifr.o_count, 2);
        tick();
        chk("basic_d2", ifr.o_data, 16'h0030);
        tick();
        chk("basic_empty", ifr.o_valid, 0);
        ready = 1'b0;

        // Delta mode with counter wrap
        clear = 1'b1; tick(); clear = 1'b0;
        cap(16'h0005); cap(16'hFFFE); cap(16'h0003);
        chk("delta_count", ifd.o_count, 3);
        chk("delta_d0", ifd.o_data, 16'h0005);
        ready = 1'b1;
        tick();
        chk("delta_d1", ifd.o_data, 16'hFFF9);
        chk("raw_d1", ifr.o_data, 16'hFFFE);
        tick();
        chk("delta_d2", ifd.o_data, 16'h0005);
        tick();
        chk("delta_empty", ifd.o_valid, 0);
        ready = 1'b0;

        // Fill, overflow on the ninth capture, drain first eight
        clear = 1'b1; tick(); clear = 1'b0;
        for (int k = 1; k <= 8; k++) cap(16'(k * 256));
        chk("fill_full", ifr.o_full, 1);
        chk("fill_ovf0", ifr.o_overflow, 0);
        cap(16'h0900);
        chk("ovf_set", ifr.o_overflow, 1);
        chk("ovf_count", ifr.o_count, 8);
        chk("ovf_full", ifr.o_full, 1);
        chk("ovf_set_d", ifd.o_overflow, 1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", ifr.o_data, 32'((i + 1) * 256));
            tick();
        end
        chk("ovf_drained", ifr.o_valid, 0);
        ready = 1'b0;
        cap(16'h0A00);
        chk("ovf_prev_kept", ifd.o_data, 16'h0200);
        chk("ovf_sticky", ifr.o_overflow, 1);

        // Push and pop together while full
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_ovf", ifr.o_overflow, 0);
        for (int k = 1; k <= 8; k++) cap(16'(k));
        value = 16'h1234; capture = 1'b1; ready = 1'b1;
        tick();
        capture = 1'b0; ready = 1'b0;
        chk("pp_count", ifr.o_count, 8);
        chk("pp_ovf", ifr.o_overflow, 0);
        chk("pp_full", ifr.o_full, 1);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", ifr.o_data, (i < 7) ? 32'(i + 2) : 32'h1234);
            tick();
        end
        chk("pp_empty", ifr.o_valid, 0);
        ready = 1'b0;

        // Clear mid-operation with capture and ready asserted
        for (int k = 1; k <= 9; k++) cap(16'(k));
        ready = 1'b1;
        repeat (4) tick();
        ready = 1'b0;
        chk("mid_count", ifd.o_count, 4);
        chk("mid_ovf", ifd.o_overflow, 1);
        clear = 1'b1; capture = 1'b1; value = 16'h7777; ready = 1'b1;
        tick();
        clear = 1'b0; capture = 1'b0; ready = 1'b0;
        chk("clr_count", ifd.o_count, 0);
        chk("clr_valid", ifd.o_valid, 0);
        chk("clr_ovf_d", ifd.o_overflow, 0);
        chk("clr_valid_r", ifr.o_valid, 0);
        cap(16'h0100);
        chk("clr_delta", ifd.o_data, 16'h0100);
        chk("clr_dcount", ifd.o_count, 1);

        // Simultaneous push and pop with one entry: new word appears at head
        value = 16'h0060; capture = 1'b1; ready = 1'b1;
        tick();
        capture = 1'b0; ready = 1'b0;
        chk("pp1_data", ifr.o_data, 16'h0060);
        chk("pp1_count", ifr.o_count, 1);
        chk("pp1_delta", ifd.o_data, 16'hFF60);

        // Reset mid-operation with a concurrent capture
        for (int k = 0; k < 4; k++) cap(16'(16'h0021 + k));
        chk("rm_count", ifr.o_count, 5);
        rst = 1'b1; capture = 1'b1; value = 16'h5555;
        tick();
        rst = 1'b0; capture = 1'b0;
        chk("rm_count0", ifr.o_count, 0);
        chk("rm_valid", ifr.o_valid, 0);
        chk("rm_full", ifr.o_full, 0);
        chk("rm_ovf", ifr.o_overflow, 0);
        chk("rm_data", ifr.o_data, 0);
        tick();
        chk("rm_stay", ifr.o_count, 0);
        cap(16'h0050);
        chk("rm_delta", ifd.o_data, 16'h0050);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_capture_fifo.md
Name: counter_capture_fifo

Overview:
- Downstream consumer of the 16-bit free-running counter value.
- On each capture strobe it snapshots the counter, either as the raw value or as the delta since the previous capture. It buffers snapshots in a small synchronous FIFO and presents them on a valid/ready output.
- Used to timestamp events, such as bus transactions or test-bench markers, against the shared counter.

Parameters:
- WIDTH, 16, width of counter value and stored entries.
- DEPTH, 8, number of FIFO entries; must be a power of two, at least 2.
- DELTA_MODE, 0:
  - 0 stores the raw counter value.
  - 1 stores i_value minus the previous accepted capture, modulo 2^WIDTH.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  reset; synchronous, active-high.
- i_value  input  WIDTH  current counter value from the upstream counter.
- i_capture  input  1  capture strobe; one capture per cycle it is high.
- i_clear  input  1  synchronous flush of FIFO, delta history and overflow flag.
- o_data  output  WIDTH  head-of-FIFO entry; valid only when o_valid.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accepts o_data when o_valid and i_ready.
- o_count  output  log2(DEPTH)+1  number of stored entries.
- o_full  output  1  o_count equals DEPTH.
- o_overflow  output  1  sticky; a capture was dropped.

Behaviour:
- Reset (i_reset high at an edge):
  - o_count=0, o_valid=0, o_full=0, o_overflow=0, o_data=0.
  - Pointers are 0; previous-capture register is 0.
- i_clear has the same effect as reset, except it is a functional input.
  - Priority: i_reset > i_clear > push/pop.
  - A push or pop in the same cycle as a clear is discarded.
- Pop: occurs when o_valid && i_ready at an edge. The head advances and o_count decrements.
- Push: requested when i_capture is high at an edge. It is accepted when !o_full, or when o_full && pop in the same cycle.
  - The accepted word is i_value sampled at that edge: raw, or delta per DELTA_MODE.
- Drop: push requested, o_full, and no pop. The word is discarded, o_overflow is set to 1, and the previous-capture register is not updated.
- Simultaneous push and pop: o_count is unchanged. When o_count=1, o_data takes the new word after the edge.
- Latency: a capture accepted at edge N makes o_valid high from edge N onward (after N), with o_data = that word if the FIFO was empty.
  - First-word fall-through.
  - o_data is driven from registered storage; no combinational path from i_value to o_data.
- Delta arithmetic:
  - Stored word = (i_value - prev) mod 2^WIDTH.
  - prev is updated to i_value on every accepted push.
  - After reset or clear prev=0, so the first delta equals the raw value.
  - Counter wrap gives the correct modular delta (e.g. prev=0xFFFE, i_value=0x0003 -> 0x0005).
- Pointers wrap modulo DEPTH. o_count distinguishes full from empty.
- When o_valid=0, o_data holds its last value. Consumers must ignore it.
- o_overflow clears only on reset or i_clear.

Decomposition:
- Package counter_capture_pkg holds:
  - CC_WIDTH = 16 default.
  - CC_DEPTH = 8 default.
  - Mode constants CC_MODE_RAW = 0 and CC_MODE_DELTA = 1.
  - Pointer-width helper (clog2).
- Sub-module sync_fifo (WIDTH, DEPTH): storage, pointers, count, full/empty, push/pop with same-cycle push-when-full-and-pop.
- The top level adds capture/delta logic, overflow flag and clear priority.

Test Plan:
- Basic capture: reset, then capture at i_value=0x0010, 0x0020, 0x0030 with i_ready=0 -> o_count=3, o_valid=1. Raising i_ready then yields o_data 0x0010, 0x0020, 0x0030 on consecutive cycles, then o_valid=0.
- Delta mode with wrap: DELTA_MODE=1, captures at 0x0005, 0xFFFE, 0x0003 -> entries 0x0005, 0xFFF9, 0x0005.
- Full and overflow: DEPTH=8, nine captures with i_ready=0 -> o_full=1, o_overflow=1, o_count=8. Drained data is the first 8 values. In delta mode, the 9th value does not alter prev.
- Push+pop when full: fill 8 entries, then capture 0x1234 with i_ready=1 in the same cycle -> o_count stays 8, o_overflow=0, and 0x1234 is read last.
- Clear mid-operation: 4 entries plus overflow set, assert i_clear together with i_capture and i_ready -> next cycle o_count=0, o_valid=0, o_overflow=0. The next delta capture at 0x0100 stores 0x0100.
- Reset mid-operation: with 5 entries stored, assert i_reset for 1 cycle concurrently with a capture -> all outputs at reset values and no entry retained.
